// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external combinational 8-bit ALU between two requesters.
// Requests are granted round-robin. The winner's opcode and operands are
// latched, driven to the ALU for HOLD_CYCLES cycles, and then the ALU result
// is captured into that port's result register, with a one-cycle done pulse.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/req1           requests, sampled only while idle
//   op0/op1 [4:0]       opcode: bit 4 = class (0 arith, 1 logic), 3:0 = code
//   a0,b0 / a1,b1 [7:0] operands, latched on acceptance
//   gnt0/gnt1           one-cycle pulse after acceptance
//   done0/done1         one-cycle pulse, matching res is valid
//   res0/res1 [7:0]     result registers, held until that port's next done
//   alu_a, alu_b [7:0]  ALU operands (zero outside EXEC)
//   alu_s1 [1:0]        ALU class select
//   alu_s2 [2:0]        ALU arithmetic code
//   alu_s3 [3:0]        ALU logic code
//   alu_o [7:0]         ALU result
//   busy                high whenever not idle
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here
// EXEC  | latched operands driven to ALU, hold counter running
// RESP  | result captured, owner's done pulse high
module alu_share_arbiter #(
   parameter int HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [4:0] op0,
   input  logic [4:0] op1,
   input  logic [7:0] a0,
   input  logic [7:0] b0,
   input  logic [7:0] a1,
   input  logic [7:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] res0,
   output logic [7:0] res1,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [1:0] alu_s1,
   output logic [2:0] alu_s2,
   output logic [3:0] alu_s3,
   input  logic [7:0] alu_o,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   state_t     state, state_nxt;
   logic       owner;
   logic       last_srv;
   logic [4:0] op_q;
   logic [7:0] a_q, b_q;
   logic [3:0] cnt;
   logic       cnt_zero;
   logic       accept;
   logic       pick1;

   assign cnt_zero = (cnt == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      pick1     = 1'b0;
      busy      = 1'b1;
      done0     = 1'b0;
      done1     = 1'b0;
      alu_a     = 8'd0;
      alu_b     = 8'd0;
      alu_s1    = 2'b00;
      alu_s2    = 3'd0;
      alu_s3    = 4'd0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (req0 || req1) begin
               accept = 1'b1;
               // On a tie, the port not served last wins.
               pick1     = req1 && (!req0 || !last_srv);
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            alu_a  = a_q;
            alu_b  = b_q;
            alu_s1 = {1'b0, op_q[4]};
            if (op_q[4]) alu_s3 = op_q[3:0];
            else         alu_s2 = op_q[2:0];
            if (cnt_zero) state_nxt = RESP;
         end
         RESP: begin
            done0     = !owner;
            done1     = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner    <= 1'b0;
         last_srv <= 1'b1;
         op_q     <= 5'd0;
         a_q      <= 8'd0;
         b_q      <= 8'd0;
         cnt      <= 4'd0;
         res0     <= 8'd0;
         res1     <= 8'd0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
      end else begin
         gnt0 <= accept && !pick1;
         gnt1 <= accept && pick1;
         if (accept) begin
            owner <= pick1;
            op_q  <= pick1 ? op1 : op0;
            a_q   <= pick1 ? a1 : a0;
            b_q   <= pick1 ? b1 : b0;
            cnt   <= HOLD_LOAD;
         end else if (state == EXEC) begin
            if (cnt_zero) begin
               last_srv <= owner;
               if (owner) res1 <= alu_o;
               else       res0 <= alu_o;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end
      end
   end

endmodule
